stream_fanout_fork: RTL
=======================

// Module: stream_fanout_fork
// PURPOSE
// - Producer-side eager fork for a broadcast stream: one upstream ready/valid stream is delivered to NUM_OUT consumers.
// - A consumer participates only when it is enabled and its route-mask bit is set. Non-participating consumers never block.
// - Tracks per-consumer delivery so each token reaches each participating consumer exactly once, even when they accept in different cycles.
// - Sits between a stream producer (sparse-tensor scanner/reader) and the interconnect tracks feeding several consumers.
// PARAMETERS
// - NUM_OUT     6    number of consumer branches (>=1)
// - DATA_WIDTH  17   token width (16-bit payload + 1 control/stop bit)
// - CNT_WIDTH   16   width of the stall performance counter
// PORTS
// - clk          in   1                      clock
// - rst_n        in   1                      asynchronous reset, active-low
// - cfg_en       in   NUM_OUT                per-branch enable (static while busy)
// - cfg_mask     in   NUM_OUT                per-branch route select (static while busy)
// - in_data      in   DATA_WIDTH             upstream token
// - in_valid     in   1                      upstream valid
// - in_ready     out  1                      buffer can accept
// - out_data     out  NUM_OUT*DATA_WIDTH     per-branch token (all branches carry the head token)
// - out_valid    out  NUM_OUT                per-branch valid
// - out_ready    in   NUM_OUT                per-branch ready
// - busy         out  1                      buffer non-empty
// - stall_cnt    out  CNT_WIDTH              saturating count of head-blocked cycles
// - stall_clr    in   1                      synchronous clear of stall_cnt
// BEHAVIOUR
// - Reset (rst_n=0, async): buffer empty, done[]=0, stall_cnt=0. All outputs low, except in_ready=1 after the first clk edge with rst_n=1.
// - active[i] = cfg_en[i] & cfg_mask[i].
// - 2-entry FIFO (head/tail regs, 1-bit pointers, 2-bit count).
//   - in_ready = (count<2). Registered, with no combinational path from out_ready.
//   - Push when in_valid&in_ready. A token pushed at edge t is visible on outputs in cycle t+1 (latency 1).
// - out_valid[i] = (count>0) & active[i] & ~done[i]. out_data[i] = head data for all i.
// - accept[i] = out_valid[i] & out_ready[i].
// - all_done = &(~active | done | accept).
//   - Head pops when count>0 & all_done. On pop, done[] clears to 0.
//   - Otherwise done[i] <= done[i] | accept[i].
// - active==0 with a non-empty buffer: head pops every cycle and no out_valid is asserted (drain/discard).
// - Simultaneous push and pop: count unchanged. Sustained throughput is 1 token/cycle when all active consumers are ready.
// - Full (count==2) with no pop: in_ready=0 next cycle. A push is never accepted while full.
// - Empty: out_valid=0, done[] held at 0.
// - Config change while busy is illegal. The bench asserts cfg stable whenever busy=1.
//   - Defined fallback: a newly inactive branch stops blocking immediately.
//   - Defined fallback: a newly active branch receives only tokens whose done bit it has not yet set.
// - stall_cnt increments when count>0 & ~all_done. It saturates at all-ones.
//   - stall_clr has priority over increment.
// - Async reset mid-transfer discards buffered tokens and done state. There is no partial-delivery recovery.
// STRUCTURE
// - Package stream_fork_pkg holds:
//   - NUM_OUT and DATA_WIDTH defaults
//   - typedef token_t (logic [DATA_WIDTH-1:0])
//   - typedef branch_mask_t (logic [NUM_OUT-1:0])
// - Sub-module stream_fifo2: 2-entry ready/valid FIFO with push, pop, count, head_data and in_ready.
// - The fork logic (done[] register, all_done reduction, stall counter) lives in the top.
// - The all_done term is the producer-side dual of the consumer ready-join: ~active | done | accept per branch, AND-reduced.
// TESTING
// - Broadcast: en=mask=6'b111111, all ready=1, push 0x00001..0x00008 back-to-back.
//   - Each branch sees 8 tokens in order, first out_valid 1 cycle after first push.
//   - in_ready stays 1 and stall_cnt=0.
// - Skewed ready: active=6'b000111, branch1 ready held 0 for 5 cycles then 1.
//   - Branches 0 and 2 each see token 0xA5 exactly once.
//   - Head pops the cycle branch1 accepts. stall_cnt=5.
//   - After 2 pushes, in_ready=0 until the pop.
// - Masked branches: en=6'b111111, mask=6'b101000, ready[5]=1, ready[3]=1, ready of others=0.
//   - Stream flows at 1 token/cycle. out_valid[0,1,2,4] never asserted.
// - No consumers: active=0, push 4 tokens.
//   - Each is discarded and in_ready stays 1. out_valid==0 throughout, busy pulses.
// - Reset mid-operation: 2 tokens buffered, done=6'b000011, drop rst_n asynchronously mid-cycle.
//   - out_valid=0 and busy=0 immediately.
//   - After release, a new token 0x1FFFF is delivered once to every active branch.
// - Counter: hold ready=0 with active=1 for 70000 cycles.
//   - stall_cnt saturates at 0xFFFF.
//   - stall_clr with a simultaneous stall gives 0 next cycle.

Source files
------------

// File: rtl/stream_fork_pkg.sv
// Shared definitions for the broadcast stream fork.
//
// Holds the default branch count, token width and stall counter width,
// plus the token and branch-mask types used by the fork, its FIFO and
// anything that talks to them.
package stream_fork_pkg;

  // Default number of consumer branches fed by one producer.
  localparam int DEF_NUM_OUT    = 6;

  // Default token width: 16-bit payload plus one control/stop bit.
  localparam int DEF_DATA_WIDTH = 17;

  // Default width of the saturating head-blocked cycle counter.
  localparam int DEF_CNT_WIDTH  = 16;

  // One stream token as carried on every branch.
  typedef logic [DEF_DATA_WIDTH-1:0] token_t;

  // One bit per consumer branch (enable, route mask, valid, ready, done).
  typedef logic [DEF_NUM_OUT-1:0] branch_mask_t;

endpackage

// File: rtl/stream_fifo2.sv
// Two-entry ready/valid FIFO used as the skid buffer in front of the fork.
//
// Ports
//   clk        clock
//   rst_n      asynchronous reset, active-low (empties the buffer)
//   push       write request; only honoured while in_ready is high
//   push_data  token written on push
//   pop        read request; only honoured while the buffer is non-empty
//   head_data  oldest buffered token (valid whenever count != 0)
//   count      number of buffered tokens, 0..2
//   in_ready   registered "can accept" flag, high whenever count < 2
//
// in_ready is a flop, so the producer never sees a combinational path
// back from the consumers' ready signals. A simultaneous push and pop
// keeps the count unchanged, giving one token per cycle sustained.
module stream_fifo2
  import stream_fork_pkg::*;
#(
  parameter int WIDTH = DEF_DATA_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [1:0]       count,
  output logic             in_ready
);

  logic [WIDTH-1:0] slot0_q;
  logic [WIDTH-1:0] slot1_q;
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       count_q;
  logic [1:0]       count_d;
  logic             in_ready_q;
  logic             do_push;
  logic             do_pop;

  // Requests are qualified here as well, so a caller that forgets to gate
  // push with in_ready cannot overwrite a live entry, and a pop on an
  // empty buffer cannot wrap the count.
  assign do_push = push & in_ready_q;
  assign do_pop  = pop & (count_q != 2'd0);

  // Next occupancy; push+pop together leaves it unchanged.
  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Storage, pointers, occupancy and the registered ready flag.
  // in_ready comes out of reset low and rises on the first clock edge
  // after release, because it is loaded from the next-state count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot0_q    <= '0;
      slot1_q    <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
      in_ready_q <= 1'b0;
    end else begin
      if (do_push) begin
        if (wr_ptr_q) begin
          slot1_q <= push_data;
        end else begin
          slot0_q <= push_data;
        end
        wr_ptr_q <= ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q    <= count_d;
      in_ready_q <= (count_d != 2'd2);
    end
  end

  assign head_data = rd_ptr_q ? slot1_q : slot0_q;
  assign count     = count_q;
  assign in_ready  = in_ready_q;

endmodule

// File: rtl/stream_fanout_fork.sv
// Producer-side eager fork: one upstream ready/valid stream broadcast to
// NUM_OUT consumer branches.
//
// Ports
//   clk        clock
//   rst_n      asynchronous reset, active-low
//   cfg_en     per-branch enable (hold stable while busy)
//   cfg_mask   per-branch route select (hold stable while busy)
//   in_data    upstream token
//   in_valid   upstream valid
//   in_ready   buffer can accept (registered)
//   out_data   NUM_OUT copies of the head token, branch i in slice i
//   out_valid  per-branch valid
//   out_ready  per-branch ready
//   busy       buffer holds at least one token
//   stall_cnt  saturating count of cycles the head was blocked
//   stall_clr  synchronous clear of stall_cnt, wins over increment
//
// A branch takes part only when both its enable and route bit are set.
// Each participating branch may accept the head in a different cycle; a
// per-branch done bit remembers who already has it so nobody sees the
// same token twice. The head leaves the buffer in the cycle the last
// outstanding branch accepts. With no participating branch the buffer
// simply drains one token per cycle.
module stream_fanout_fork
  import stream_fork_pkg::*;
#(
  parameter int NUM_OUT    = DEF_NUM_OUT,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_OUT-1:0]            cfg_en,
  input  logic [NUM_OUT-1:0]            cfg_mask,
  input  logic [DATA_WIDTH-1:0]         in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [NUM_OUT*DATA_WIDTH-1:0] out_data,
  output logic [NUM_OUT-1:0]            out_valid,
  input  logic [NUM_OUT-1:0]            out_ready,
  output logic                          busy,
  output logic [CNT_WIDTH-1:0]          stall_cnt,
  input  logic                          stall_clr
);

  logic [DATA_WIDTH-1:0] head_data;
  logic [1:0]            count;
  logic                  fifo_ready;
  logic                  push;
  logic                  pop;
  logic                  nonempty;
  logic [NUM_OUT-1:0]    active;
  logic [NUM_OUT-1:0]    done_q;
  logic [NUM_OUT-1:0]    accept;
  logic                  all_done;
  logic [CNT_WIDTH-1:0]  stall_cnt_q;

  // Buffer between the producer and the branches.
  stream_fifo2 #(
    .WIDTH     (DATA_WIDTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (in_data),
    .pop       (pop),
    .head_data (head_data),
    .count     (count),
    .in_ready  (fifo_ready)
  );

  assign push     = in_valid & fifo_ready;
  assign nonempty = (count != 2'd0);
  assign active   = cfg_en & cfg_mask;

  // A branch is offered the head only until it has taken it once.
  assign out_valid = {NUM_OUT{nonempty}} & active & ~done_q;
  assign accept    = out_valid & out_ready;

  // Producer-side dual of a ready-join: a branch no longer holds the head
  // if it is not participating, already has it, or is taking it now.
  // Because ~active is part of the term, a branch that is switched off
  // mid-token stops blocking in the same cycle.
  assign all_done = &(~active | done_q | accept);
  assign pop      = nonempty & all_done;

  // Delivery bookkeeping. Cleared on every pop so the next head starts
  // fresh, and forced clear while empty so stale bits can never survive
  // into a later token. A branch that becomes active mid-token keeps any
  // done bit it already holds and is only offered what it still lacks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q <= '0;
    end else if (!nonempty || pop) begin
      done_q <= '0;
    end else begin
      done_q <= done_q | accept;
    end
  end

  // Head-blocked cycle counter. Sticks at all-ones rather than wrapping
  // so a long stall never reads back as a short one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else if (stall_clr) begin
      stall_cnt_q <= '0;
    end else if (nonempty && !all_done && !(&stall_cnt_q)) begin
      stall_cnt_q <= stall_cnt_q + CNT_WIDTH'(1);
    end
  end

  assign out_data  = {NUM_OUT{head_data}};
  assign in_ready  = fifo_ready;
  assign busy      = nonempty;
  assign stall_cnt = stall_cnt_q;

endmodule
